// File: rtl/console_mux_pkg.sv
// Shared types and constants for the console-mux UART stages.
package console_mux_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int CLKS_PER_BIT_DEFAULT  = 104;
   localparam int SETTLE_CYCLES_DEFAULT = 2;

   localparam logic UART_IDLE  = 1'b1;
   localparam logic UART_START = 1'b0;

endpackage

// File: rtl/baud_counter.sv
// Bit-period counter: pulses tick at CLKS_PER_BIT-1 and holds there until cleared.
module baud_counter
   import console_mux_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (cnt != TERM) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage serialising bytes as 8N1 UART; define FIFO_UART_TX_PARITY_EN for 8E1.
module fifo_uart_tx
   import console_mux_pkg::*;
#(
   parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEFAULT,
   parameter int WIDTH         = 8,
   parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd,
   output logic             tx,
   output logic             busy
);

   localparam int SW = $clog2(SETTLE_CYCLES);
   localparam int IW = $clog2(WIDTH);

   uart_state_t      state;
   logic [SW-1:0]    settle_cnt;
   logic [IW-1:0]    bit_idx;
   logic [WIDTH-1:0] shift;
   logic             settle_done;
   logic             baud_clear;
   logic             baud_tick;
`ifdef FIFO_UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
   // Pop coincides with the latch edge, so the FIFO's next word cannot corrupt this byte.
   assign fifo_rd     = (state == SETTLE) && settle_done && !fifo_empty;
   assign baud_clear  = (state == IDLE) || (state == SETTLE) || baud_tick;

   baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst_n(rst_n),
      .clear(baud_clear),
      .tick (baud_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx         <= UART_IDLE;
         busy       <= 1'b0;
         settle_cnt <= '0;
         bit_idx    <= '0;
         shift      <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               tx <= UART_IDLE;
               if (!fifo_empty) begin
                  state      <= SETTLE;
                  settle_cnt <= '0;
                  busy       <= 1'b1;
               end
            end
            SETTLE: begin
               if (!settle_done) begin
                  settle_cnt <= settle_cnt + 1'b1;
               end else if (fifo_empty) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  shift <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                  parity_bit <= ^fifo_data;
`endif
                  state <= START;
                  tx    <= UART_START;
               end
            end
            START: begin
               if (baud_tick) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx      <= shift[0];
               end
            end
            DATA: begin
               if (baud_tick) begin
                  shift <= shift >> 1;
                  if (bit_idx == IW'(WIDTH - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= parity_bit;
`else
                     state <= STOP;
                     tx    <= UART_IDLE;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shift[1];
                  end
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
               if (baud_tick) begin
                  state <= STOP;
                  tx    <= UART_IDLE;
               end
            end
`endif
            STOP: begin
               if (baud_tick) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= UART_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
